// File: rtl/mb_mode_scheduler.sv
// Macroblock mode-pick scheduler.
// Walks a frame of mb_w x mb_h macroblocks in raster order. For each one it
// launches the luma and chroma mode picks together, waits for both to
// finish, presents the result for writeback, then advances the coordinates.
//
// Handshake: the writeback transfer happens on a rising edge where mb_valid
// and mb_ready are both high. Once raised, mb_valid stays high until that
// transfer, and x/y stay stable from launch until the transfer is complete.
//
// Every output is either a register or a direct decode of the one-hot state
// register, so no input has a combinational path to an output.
module mb_mode_scheduler #(
  parameter int COORD_W = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_start,
  input  logic [COORD_W-1:0] mb_w,
  input  logic [COORD_W-1:0] mb_h,
  output logic               luma_start,
  input  logic               luma_done,
  output logic               uv_start,
  input  logic               uv_done,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               mb_valid,
  input  logic               mb_ready,
  output logic               busy,
  output logic               frame_done,
  output logic [5:0]         state_dbg
);

  typedef enum logic [5:0] {
    IDLE   = 6'b000001,
    LAUNCH = 6'b000010,
    RUN    = 6'b000100,
    EMIT   = 6'b001000,
    ADV    = 6'b010000,
    FDONE  = 6'b100000
  } state_t;

  state_t             state;
  state_t             state_nx;
  logic [COORD_W-1:0] w_lat;
  logic [COORD_W-1:0] h_lat;
  logic [COORD_W-1:0] w_last;
  logic [COORD_W-1:0] h_last;
  logic               l_ok;
  logic               u_ok;
  logic               x_at_end;
  logic               last_mb;

  // Last valid column/row index; only used while the latched dims are nonzero.
  assign w_last   = w_lat - COORD_W'(1);
  assign h_last   = h_lat - COORD_W'(1);
  assign x_at_end = (x == w_last);
  assign last_mb  = x_at_end && (y == h_last);

  // State register; reset abandons any frame in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (frame_start) begin
          // An empty frame skips straight to completion.
          if ((mb_w == '0) || (mb_h == '0)) state_nx = FDONE;
          else                              state_nx = LAUNCH;
        end
      end
      LAUNCH: state_nx = RUN;
      RUN: begin
        // A done pulse arriving this cycle counts as if its flag were set.
        if ((l_ok || luma_done) && (u_ok || uv_done)) state_nx = EMIT;
      end
      EMIT: begin
        if (mb_ready) state_nx = ADV;
      end
      ADV:     state_nx = last_mb ? FDONE : LAUNCH;
      FDONE:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Frame dims, coordinates and sticky pick-done flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_lat <= '0;
      h_lat <= '0;
      x     <= '0;
      y     <= '0;
      l_ok  <= 1'b0;
      u_ok  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (frame_start) begin
            w_lat <= mb_w;
            h_lat <= mb_h;
            x     <= '0;
            y     <= '0;
          end
        end
        LAUNCH: begin
          l_ok <= 1'b0;
          u_ok <= 1'b0;
        end
        RUN: begin
          if (luma_done) l_ok <= 1'b1;
          if (uv_done)   u_ok <= 1'b1;
        end
        ADV: begin
          // The last macroblock holds its coordinates so neither ever
          // reaches the latched width or height.
          if (!last_mb) begin
            if (x_at_end) begin
              x <= '0;
              y <= y + COORD_W'(1);
            end else begin
              x <= x + COORD_W'(1);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Output decode straight from the state register.
  assign luma_start = (state == LAUNCH);
  assign uv_start   = (state == LAUNCH);
  assign mb_valid   = (state == EMIT);
  assign busy       = (state != IDLE);
  assign frame_done = (state == FDONE);
  assign state_dbg  = state;

endmodule

// File: tb/tb_mb_mode_scheduler.sv
// Directed testbench for mb_mode_scheduler.
module tb_mb_mode_scheduler;

  localparam int COORD_W = 10;
  localparam logic [5:0] S_IDLE  = 6'b000001;
  localparam logic [5:0] S_RUN   = 6'b000100;
  localparam logic [5:0] S_EMIT  = 6'b001000;

  logic               clk;
  logic               rst_n;
  logic               frame_start;
  logic [COORD_W-1:0] mb_w;
  logic [COORD_W-1:0] mb_h;
  logic               luma_start;
  logic               luma_done;
  logic               uv_start;
  logic               uv_done;
  logic [COORD_W-1:0] x;
  logic [COORD_W-1:0] y;
  logic               mb_valid;
  logic               mb_ready;
  logic               busy;
  logic               frame_done;
  logic [5:0]         state_dbg;

  int checks;
  int failures;

  mb_mode_scheduler #(.COORD_W(COORD_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_start(frame_start),
    .mb_w       (mb_w),
    .mb_h       (mb_h),
    .luma_start (luma_start),
    .luma_done  (luma_done),
    .uv_start   (uv_start),
    .uv_done    (uv_done),
    .x          (x),
    .y          (y),
    .mb_valid   (mb_valid),
    .mb_ready   (mb_ready),
    .busy       (busy),
    .frame_done (frame_done),
    .state_dbg  (state_dbg)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; inputs are driven and outputs sampled 1 time unit
  // after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called in the LAUNCH cycle. Pulses luma_done kl cycles and uv_done ku
  // cycles after launch, optionally with a stray frame_start in the first
  // RUN cycle, and returns in the first EMIT cycle.
  task automatic launch_and_pick(input int ex, input int ey, input int kl, input int ku,
                                 input bit fs_in_run);
    int n;
    n = (kl > ku) ? kl : ku;
    chk("launch_luma_start", luma_start, 1);
    chk("launch_uv_start", uv_start, 1);
    chk("launch_x", x, ex);
    chk("launch_y", y, ey);
    chk("launch_valid_low", mb_valid, 0);
    for (int i = 1; i <= n; i++) begin
      tick();
      chk("run_state", state_dbg, S_RUN);
      chk("run_valid_low", mb_valid, 0);
      chk("run_luma_start_low", luma_start, 0);
      luma_done   = (i == kl);
      uv_done     = (i == ku);
      frame_start = fs_in_run && (i == 1);
    end
    tick();
    luma_done   = 1'b0;
    uv_done     = 1'b0;
    frame_start = 1'b0;
    chk("emit_valid", mb_valid, 1);
    chk("emit_x", x, ex);
    chk("emit_y", y, ey);
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    rst_n       = 1'b0;
    frame_start = 1'b0;
    mb_w        = '0;
    mb_h        = '0;
    luma_done   = 1'b0;
    uv_done     = 1'b0;
    mb_ready    = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_luma_start", luma_start, 0);
    chk("rst_uv_start", uv_start, 0);
    chk("rst_valid", mb_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_x", x, 0);
    chk("rst_y", y, 0);
    chk("rst_state", state_dbg, S_IDLE);
    rst_n = 1'b1;
    tick();
    chk("idle_busy", busy, 0);

    // 2x2 frame, picks finish 5 cycles after launch, writeback always ready
    mb_w = 2; mb_h = 2; mb_ready = 1'b1; frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    launch_and_pick(0, 0, 5, 5, 1'b0);
    tick();
    chk("f1_adv_valid_low", mb_valid, 0);
    chk("f1_adv_busy", busy, 1);
    tick();
    launch_and_pick(1, 0, 5, 5, 1'b0);
    tick();
    tick();
    launch_and_pick(0, 1, 5, 5, 1'b0);
    tick();
    tick();
    launch_and_pick(1, 1, 5, 5, 1'b0);
    tick();
    chk("f1_last_adv_no_launch", luma_start, 0);
    tick();
    chk("f1_frame_done", frame_done, 1);
    chk("f1_fdone_no_launch", luma_start, 0);
    chk("f1_fdone_busy", busy, 1);
    tick();
    chk("f1_frame_done_pulse", frame_done, 0);
    chk("f1_idle_busy", busy, 0);
    chk("f1_idle_state", state_dbg, S_IDLE);

    // 1x2 frame; dims change after latch; uv_done 10 cycles after luma_done,
    // then coincident done pulses
    mb_w = 1; mb_h = 2; frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    mb_w = 5; mb_h = 7;
    launch_and_pick(0, 0, 2, 12, 1'b0);
    tick();
    tick();
    launch_and_pick(0, 1, 1, 1, 1'b0);
    tick();
    tick();
    chk("f2_frame_done", frame_done, 1);
    tick();
    chk("f2_idle_busy", busy, 0);

    // 2x1 frame; writeback stalls 7 cycles with a stray uv_done in EMIT;
    // stray frame_start during the second macroblock's RUN
    mb_w = 2; mb_h = 1; mb_ready = 1'b0; frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    launch_and_pick(0, 0, 3, 1, 1'b0);
    for (int i = 2; i <= 8; i++) begin
      uv_done = (i == 3);
      tick();
      chk("stall_valid", mb_valid, 1);
      chk("stall_x", x, 0);
      chk("stall_y", y, 0);
      chk("stall_no_launch", luma_start, 0);
      chk("stall_state", state_dbg, S_EMIT);
    end
    uv_done  = 1'b0;
    mb_ready = 1'b1;
    tick();
    chk("stall_adv_valid_low", mb_valid, 0);
    chk("stall_adv_no_launch", luma_start, 0);
    tick();
    launch_and_pick(1, 0, 1, 2, 1'b1);
    tick();
    tick();
    chk("f3_frame_done", frame_done, 1);
    tick();
    chk("f3_idle_busy", busy, 0);
    chk("f3_frame_done_pulse", frame_done, 0);

    // Zero-width frame completes immediately with no launches
    mb_w = 0; mb_h = 3; frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("zero_frame_done", frame_done, 1);
    chk("zero_no_luma_start", luma_start, 0);
    chk("zero_no_uv_start", uv_start, 0);
    chk("zero_busy", busy, 1);
    tick();
    chk("zero_frame_done_pulse", frame_done, 0);
    chk("zero_idle_busy", busy, 0);
    chk("zero_no_luma_start_after", luma_start, 0);

    // Reset during RUN at (1,0) abandons the frame
    mb_w = 2; mb_h = 2; frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    launch_and_pick(0, 0, 1, 1, 1'b0);
    tick();
    tick();
    chk("pre_rst_launch", luma_start, 1);
    chk("pre_rst_x", x, 1);
    tick();
    chk("pre_rst_run", state_dbg, S_RUN);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valid", mb_valid, 0);
    chk("mid_rst_luma_start", luma_start, 0);
    chk("mid_rst_uv_start", uv_start, 0);
    chk("mid_rst_frame_done", frame_done, 0);
    chk("mid_rst_x", x, 0);
    chk("mid_rst_y", y, 0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_no_frame_done", frame_done, 0);
      chk("post_rst_idle", busy, 0);
      chk("post_rst_no_launch", luma_start, 0);
    end

    // Fresh 1x1 frame after reset starts at (0,0)
    mb_w = 1; mb_h = 1; frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    launch_and_pick(0, 0, 1, 1, 1'b0);
    tick();
    tick();
    chk("f5_frame_done", frame_done, 1);
    tick();
    chk("f5_idle_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
